clk_divider_multi: RTL

- Multi-channel programmable clock/tick generator; successor to the single-channel divider.
- Each of NCH channels has a runtime period, a high-time (duty), an enable and a single-cycle tick pulse.
- Config updates are glitch-free: written into per-channel shadow registers and applied only on a period boundary.
- All channels can be phase-aligned with a common sync strobe. Feeds LED/scan/baud timing in the display and IO logic.

---
 rtl/clk_divider_multi.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock/tick divider with per-channel shadowed config.
// Optional per-channel phase offset when CLKDIV_PHASE_EN is defined.
module clk_divider_multi #(
  parameter int NCH        = 4,
  parameter int N          = 28,
  parameter int DEF_PERIOD = 49999999,
  parameter int DEF_HIGH   = 25000000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NCH-1:0]                         en,
  input  logic                                   sync,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [N-1:0]                           cfg_period,
  input  logic [N-1:0]                           cfg_high,
`ifdef CLKDIV_PHASE_EN
  input  logic [N-1:0]                           cfg_phase,
`endif
  output logic                                   cfg_err,
  output logic [NCH-1:0]                         out_clk,
  output logic [NCH-1:0]                         tick
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW:0]  NCH_W = (CW + 1)'(NCH);
  localparam logic [N-1:0] DEF_P = N'(DEF_PERIOD);
  localparam logic [N-1:0] DEF_H = N'(DEF_HIGH);

  logic [N-1:0]   cnt      [NCH];
  logic [N-1:0]   cnt_n    [NCH];
  logic [N-1:0]   per_act  [NCH];
  logic [N-1:0]   per_sh   [NCH];
  logic [N-1:0]   per_n    [NCH];
  logic [N-1:0]   high_act [NCH];
  logic [N-1:0]   high_sh  [NCH];
  logic [N-1:0]   high_n   [NCH];
  logic [N-1:0]   start_n  [NCH];
`ifdef CLKDIV_PHASE_EN
  logic [N-1:0]   ph_act   [NCH];
  logic [N-1:0]   ph_sh    [NCH];
  logic [N-1:0]   ph_n     [NCH];
`endif

  logic [NCH-1:0] running, run_n;
  logic [NCH-1:0] pending, pend_n;
  logic [NCH-1:0] wr_hit, wrap, apply;
  logic [NCH-1:0] out_q, out_n;
  logic [NCH-1:0] tick_q, tick_n;
  logic           err_q, err_n;

  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) cfg_ready = ~pending[i];
    end
  end

  assign err_n = cfg_valid & ~({1'b0, cfg_ch} < NCH_W);

  // Outputs are computed from the next-cycle count and the next-cycle active
  // config so that the registered outputs line up with the registered count.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      wr_hit[i] = cfg_valid & (cfg_ch == CW'(i)) & ~pending[i];
      wrap[i]   = (cnt[i] == per_act[i]);
      apply[i]  = pending[i] & (~en[i] | (running[i] & (sync | wrap[i])));

      per_n[i]  = apply[i] ? per_sh[i]  : per_act[i];
      high_n[i] = apply[i] ? high_sh[i] : high_act[i];
`ifdef CLKDIV_PHASE_EN
      ph_n[i]    = apply[i] ? ph_sh[i] : ph_act[i];
      start_n[i] = (ph_n[i] < per_n[i]) ? ph_n[i] : per_n[i];
`else
      start_n[i] = '0;
`endif

      run_n[i] = running[i];
      cnt_n[i] = cnt[i];
      if (!en[i]) begin
        run_n[i] = 1'b0;
        cnt_n[i] = '0;
      end else if (!running[i]) begin
        run_n[i] = 1'b1;
        cnt_n[i] = start_n[i];
      end else if (sync) begin
        cnt_n[i] = start_n[i];
      end else if (wrap[i]) begin
        cnt_n[i] = '0;
      end else begin
        cnt_n[i] = cnt[i] + N'(1);
      end

      // wr_hit requires pending=0 and apply requires pending=1: never both.
      pend_n[i] = wr_hit[i] | (pending[i] & ~apply[i]);
      out_n[i]  = run_n[i] & (cnt_n[i] < high_n[i]);
      tick_n[i] = run_n[i] & (cnt_n[i] == per_n[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]      <= '0;
        per_act[i]  <= DEF_P;
        per_sh[i]   <= DEF_P;
        high_act[i] <= DEF_H;
        high_sh[i]  <= DEF_H;
`ifdef CLKDIV_PHASE_EN
        ph_act[i]   <= '0;
        ph_sh[i]    <= '0;
`endif
      end
      running <= '0;
      pending <= '0;
      out_q   <= '0;
      tick_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]      <= cnt_n[i];
        per_act[i]  <= per_n[i];
        high_act[i] <= high_n[i];
`ifdef CLKDIV_PHASE_EN
        ph_act[i]   <= ph_n[i];
`endif
        if (wr_hit[i]) begin
          per_sh[i]  <= cfg_period;
          high_sh[i] <= cfg_high;
`ifdef CLKDIV_PHASE_EN
          ph_sh[i]   <= cfg_phase;
`endif
        end
      end
      running <= run_n;
      pending <= pend_n;
      out_q   <= out_n;
      tick_q  <= tick_n;
      err_q   <= err_n;
    end
  end

  assign out_clk = out_q;
  assign tick    = tick_q;
  assign cfg_err = err_q;

endmodule
